fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of instruction entries; it SHALL be a power of two and at least 2.
REQ-002 The port clock SHALL be an input, 1 bit wide, and is the single clock; all state SHALL update on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide, and is the reset; it SHALL be asynchronous and active-high.
REQ-004 The port FetchValid SHALL be an input, 1 bit wide, and indicates that a fetch response is present this cycle.
REQ-005 The port FetchInstr SHALL be an input, `INSTRSIZE wide, and carries the fetched instruction word.
REQ-006 The port FetchPc SHALL be an input, 32 bits wide, and carries the address of FetchInstr.
REQ-007 The port FetchReady SHALL be an output, 1 bit wide, and indicates that the queue accepts a push this cycle.
REQ-008 The port StallD SHALL be an input, 1 bit wide, and indicates that decode holds its current instruction.
REQ-009 The port FlushD SHALL be an input, 1 bit wide, and indicates a branch redirect or exception that discards all queued instructions.
REQ-010 The port InstrD SHALL be an output, `INSTRSIZE wide, and carries the head instruction that feeds the decode stage.
REQ-011 The port PcD SHALL be an output, 32 bits wide, and carries the PC of InstrD.
REQ-012 The port ValidD SHALL be an output, 1 bit wide, and indicates that InstrD/PcD hold a real instruction.

Function
REQ-013 The queue SHALL be a circular buffer of DEPTH entries, each holding {pc, instr}, with a write pointer, a read pointer (each log2(DEPTH) bits, wrapping modulo DEPTH) and a count register (log2(DEPTH)+1 bits, range 0..DEPTH).
REQ-014 FetchReady SHALL equal (count != DEPTH) && !FlushD, derived combinationally from registered state.
REQ-015 A push SHALL occur when FetchValid && FetchReady: the entry is written at the write pointer and the write pointer increments.
REQ-016 A pop SHALL occur when ValidD && !StallD && !FlushD: the read pointer increments.
REQ-017 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-018 ValidD SHALL equal (count != 0); there SHALL be no bypass, so a push reaches InstrD no earlier than the next cycle (1-cycle latency).
REQ-019 When ValidD is 0, InstrD SHALL be 32'h0 (NOP) and PcD SHALL be 32'h0.
REQ-020 When ValidD is 1, InstrD and PcD SHALL present the entry at the read pointer; they SHALL stay stable while StallD is 1.
REQ-021 When full (count == DEPTH), FetchReady SHALL be 0 even if a pop occurs that same cycle; no same-cycle full-slot reuse is permitted.
REQ-022 FlushD SHALL have priority over every other event: on the next edge count, the read pointer and the write pointer SHALL all return to 0; any FetchValid in that cycle SHALL be discarded and no pop SHALL occur.
REQ-023 FlushD together with StallD SHALL still flush.
REQ-024 The state machine SHALL be derived from count, with states EMPTY (count=0), PARTIAL and FULL (count=DEPTH). The transitions are:
- EMPTY to PARTIAL on push.
- PARTIAL to FULL on push without pop at count=DEPTH-1.
- PARTIAL to EMPTY on pop without push at count=1.
- FULL to PARTIAL on pop.
- Any state to EMPTY on FlushD.

Reset
REQ-025 While reset=1, count, the read pointer and the write pointer SHALL be 0, ValidD=0, InstrD=0, PcD=0 and FetchReady=0.
REQ-026 Entry storage SHALL NOT require reset.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-028 On the first edge after reset deassertion, FetchReady SHALL be 1.

Structure
REQ-029 `INSTRSIZE SHALL come from defines.vh, and the NOP value, PC width and the default queue depth SHALL be added there as shared constants.
REQ-030 Storage SHALL be a sub-module fetch_queue_mem, a DEPTH-entry, 64-bit, 1-write/1-async-read register array; pointer, count and flush control SHALL live in fetch_queue.
REQ-031 InstrD SHALL connect directly to the decode block's InstrD input.

Verification
REQ-032 Reset then idle: FetchValid=0 for 5 cycles SHALL keep ValidD=0, InstrD=0 and FetchReady=1.
REQ-033 Single push: FetchInstr=32'h24080005, FetchPc=32'hBFC00000 for one cycle with StallD=0 SHALL make the next cycle show ValidD=1, InstrD=32'h24080005, PcD=32'hBFC00000, and ValidD=0 the cycle after.
REQ-034 Fill: push 4 words with StallD=1 SHALL give FetchReady=0 after the 4th push; a 5th FetchValid SHALL be ignored; releasing StallD SHALL pop the 4 words in order, one per cycle.
REQ-035 Wrap-around: 10 back-to-back pushes with StallD=0 SHALL deliver all 10 to decode in order with no gaps after the first cycle, and the pointers SHALL wrap twice.
REQ-036 Flush: with 3 entries queued, FlushD=1 together with FetchValid=1 SHALL give ValidD=0 and count=0 on the next cycle, and the pushed word SHALL never appear at InstrD.
REQ-037 Async reset: asserting reset mid-cycle with 2 entries queued SHALL drop ValidD and InstrD to 0 before the next clock edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the fetch queue: instruction/PC widths, NOP,
// default depth, the queue state enum and the stored entry layout.
`ifndef FETCH_QUEUE_DEFINES_VH
`define FETCH_QUEUE_DEFINES_VH
`define INSTRSIZE 32
`define PCSIZE 32
`define NOP_INSTR 32'h00000000
`define FQ_DEFAULT_DEPTH 4
`endif

package fetch_queue_pkg;

  localparam int InstrW       = `INSTRSIZE;
  localparam int PcW          = `PCSIZE;
  localparam int EntryW       = PcW + InstrW;
  localparam int DefaultDepth = `FQ_DEFAULT_DEPTH;
  localparam logic [InstrW-1:0] NopInstr = `NOP_INSTR;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fqState_e;

  typedef struct packed {
    logic [PcW-1:0]    pc;
    logic [InstrW-1:0] instr;
  } fqEntry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x {pc, instr}, one write port and
// one asynchronous read port. Contents are deliberately not reset.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DefaultDepth,
  localparam int AddrW = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wrEn_i,
  input  logic [AddrW-1:0]  wrAddr_i,
  input  logic [EntryW-1:0] wrData_i,
  input  logic [AddrW-1:0]  rdAddr_i,
  output logic [EntryW-1:0] rdData_o
);

  logic [EntryW-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: circular buffer with
// pointer/count control, flush priority and no push-to-decode bypass.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DefaultDepth
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  FetchValid,
  input  logic [`INSTRSIZE-1:0] FetchInstr,
  input  logic [`PCSIZE-1:0]    FetchPc,
  output logic                  FetchReady,
  input  logic                  StallD,
  input  logic                  FlushD,
  output logic [`INSTRSIZE-1:0] InstrD,
  output logic [`PCSIZE-1:0]    PcD,
  output logic                  ValidD
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [CntW-1:0] count_q, count_d;
  fqState_e        state_q, state_d;
  logic            push, pop;
  fqEntry_t        wrEntry, rdEntry;

  // A full queue never accepts, even if the head leaves in the same cycle.
  assign FetchReady = (count_q != CntFull) && !FlushD && !reset;
  assign ValidD     = (state_q != EMPTY);
  assign push       = FetchValid && FetchReady;
  assign pop        = ValidD && !StallD && !FlushD;
  assign wrEntry    = {FetchPc, FetchInstr};

  fetch_queue_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clock   (clock),
    .wrEn_i  (push),
    .wrAddr_i(wrPtr_q),
    .wrData_i(wrEntry),
    .rdAddr_i(rdPtr_q),
    .rdData_o(rdEntry)
  );

  assign InstrD = ValidD ? rdEntry.instr : NopInstr;
  assign PcD    = ValidD ? rdEntry.pc : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      state_q <= EMPTY;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    state_d = state_q;
    if (FlushD) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      state_d = EMPTY;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
      unique case (state_q)
        EMPTY:   if (push) state_d = PARTIAL;
        PARTIAL: begin
          if (push && !pop && count_q == CntLast) state_d = FULL;
          else if (pop && !push && count_q == CntOne) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = PARTIAL;
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for idle/push/fill/drain,
// then hand-written flush, wrap-around and asynchronous reset sequences.
module tb_fetch_queue;

  logic        clock;
  logic        reset;
  logic        FetchValid;
  logic [31:0] FetchInstr;
  logic [31:0] FetchPc;
  logic        FetchReady;
  logic        StallD;
  logic        FlushD;
  logic [31:0] InstrD;
  logic [31:0] PcD;
  logic        ValidD;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic        expReady;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fetch_queue #(
    .DEPTH(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .FetchValid(FetchValid),
    .FetchInstr(FetchInstr),
    .FetchPc   (FetchPc),
    .FetchReady(FetchReady),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .InstrD    (InstrD),
    .PcD       (PcD),
    .ValidD    (ValidD)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expInstr,
                             input logic [31:0] expPc, input logic expReady);
    checkField({name, " ValidD"}, {31'b0, ValidD}, {31'b0, expValid});
    checkField({name, " InstrD"}, InstrD, expInstr);
    checkField({name, " PcD"}, PcD, expPc);
    checkField({name, " FetchReady"}, {31'b0, FetchReady}, {31'b0, expReady});
  endtask

  task automatic applyStimulus(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                               input logic stall, input logic flush);
    FetchValid = fv;
    FetchInstr = instr;
    FetchPc    = pc;
    StallD     = stall;
    FlushD     = flush;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic addVec(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                        input logic stall, input logic flush, input logic ev,
                        input logic [31:0] ei, input logic [31:0] ep, input logic er,
                        input string name);
    vec_t v;
    v.fv = fv; v.instr = instr; v.pc = pc; v.stall = stall; v.flush = flush;
    v.expValid = ev; v.expInstr = ei; v.expPc = ep; v.expReady = er; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) addVec(0, 0, 0, 0, 0, 0, 0, 0, 1, "idle");
    addVec(1, 32'h24080005, 32'hBFC00000, 0, 0, 1, 32'h24080005, 32'hBFC00000, 1, "single push");
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1, "single drain");
    addVec(1, 32'hA0000001, 32'h00001000, 1, 0, 1, 32'hA0000001, 32'h00001000, 1, "fill1");
    addVec(1, 32'hA0000002, 32'h00001004, 1, 0, 1, 32'hA0000001, 32'h00001000, 1, "fill2");
    addVec(1, 32'hA0000003, 32'h00001008, 1, 0, 1, 32'hA0000001, 32'h00001000, 1, "fill3");
    addVec(1, 32'hA0000004, 32'h0000100C, 1, 0, 1, 32'hA0000001, 32'h00001000, 0, "fill4 full");
    addVec(1, 32'hA0000005, 32'h00001010, 1, 0, 1, 32'hA0000001, 32'h00001000, 0, "fill5 ignored");
    addVec(1, 32'hA0000006, 32'h00001014, 0, 0, 1, 32'hA0000002, 32'h00001004, 1, "pop at full");
    addVec(0, 0, 0, 0, 0, 1, 32'hA0000003, 32'h00001008, 1, "drain3");
    addVec(0, 0, 0, 0, 0, 1, 32'hA0000004, 32'h0000100C, 1, "drain4");
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1, "drain empty");

    // Reset state, held across an edge
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("reset", 0, 0, 0, 0);
    #10;
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].fv, vecs[i].instr, vecs[i].pc, vecs[i].stall, vecs[i].flush);
      stepCycle();
      checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expInstr, vecs[i].expPc, vecs[i].expReady);
    end

    // Flush with three entries queued and a simultaneous fetch
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'hB0000000 + i, 32'h00002000 + 4 * i, 1, 0);
      stepCycle();
    end
    checkOutput("flush pre", 1, 32'hB0000000, 32'h00002000, 1);
    applyStimulus(1, 32'hDEADBEEF, 32'h0000BAD0, 1, 1);
    #1;
    checkField("flush ready", {31'b0, FetchReady}, 32'd0);
    stepCycle();
    checkOutput("flush edge", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("post flush", 0, 0, 0, 1);
    end
    applyStimulus(1, 32'hC0000000, 32'h00003000, 0, 0);
    stepCycle();
    checkOutput("push after flush", 1, 32'hC0000000, 32'h00003000, 1);
    applyStimulus(0, 0, 0, 0, 1);
    stepCycle();
    checkOutput("realign flush", 0, 0, 0, 0);

    // Ten back-to-back pushes with decode free-running
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'hE0000000 + i, 32'h00004000 + 4 * i, 0, 0);
      stepCycle();
      checkOutput("wrap stream", 1, 32'hE0000000 + i, 32'h00004000 + 4 * i, 1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("wrap end", 0, 0, 0, 1);

    // Asynchronous reset mid-cycle with two entries queued
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 32'hD0000000 + i, 32'h00005000 + 4 * i, 1, 0);
      stepCycle();
    end
    checkOutput("areset pre", 1, 32'hD0000000, 32'h00005000, 1);
    applyStimulus(0, 0, 0, 1, 0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("areset async", 0, 0, 0, 0);
    stepCycle();
    checkOutput("areset held", 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("areset release", 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
